serv_ram_arbiter: RTL and testbench

- Sits between the SERV core's Wishbone-style ibus/dbus and the single-port RAM32 macro (1-cycle synchronous read, 4-bit byte write enable).
- Serialises instruction fetches and data accesses onto the one RAM port and generates correct ack/rdt timing.
- Provides a byte-wide host load/readback port so the RAM can be programmed through ui_in/uio_in while the core is held off.
- Flags out-of-range bus accesses.

---
 rtl/serv_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_serv_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_ram_arbiter.sv
// Single-port RAM32 arbiter for SERV: serialises ibus/dbus onto one RAM port
// with fixed 2-cycle latency, plus a byte-wide host load/readback path.
module serv_ram_arbiter #(
  parameter int AW        = 5,
  parameter bit DBUS_PRIO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_en,
  input  logic [AW+1:0] host_addr,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_rdy,
  input  logic          ibus_cyc,
  input  logic [31:0]   ibus_adr,
  output logic [31:0]   ibus_rdt,
  output logic          ibus_ack,
  input  logic          dbus_cyc,
  input  logic [31:0]   dbus_adr,
  input  logic          dbus_we,
  input  logic [31:0]   dbus_dat,
  input  logic [3:0]    dbus_sel,
  output logic [31:0]   dbus_rdt,
  output logic          dbus_ack,
  output logic          ram_en,
  output logic [AW-1:0] ram_a,
  output logic [3:0]    ram_we,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do,
  output logic          err_oob
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          gnt_dbus;   // granted master of the current transaction, doubles as last_grant
  logic [AW-1:0] word_q;
  logic          oob_q;
  logic          we_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [1:0]    lane_q;
  logic          host_vld_q;

  logic          host_act;
  logic          req_any;
  logic          pick_dbus;
  logic          grant;
  logic          unused_bits;

  assign unused_bits = &{1'b0, ibus_adr[1:0], dbus_adr[1:0]};

  always_comb begin
    // rst_n gates the host path so no RAM write can leak out while reset is held
    host_act = (state == IDLE) && host_en && rst_n;
    req_any  = ibus_cyc | dbus_cyc;
    if (ibus_cyc && dbus_cyc)
      pick_dbus = DBUS_PRIO ? 1'b1 : ~gnt_dbus;
    else
      pick_dbus = dbus_cyc;
    grant = (state == IDLE) && !host_en && req_any;

    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_a    = '0;
    ram_we   = '0;
    ram_di   = '0;
    host_rdy = host_act;
    ibus_ack = 1'b0;
    ibus_rdt = '0;
    dbus_ack = 1'b0;
    dbus_rdt = '0;

    if (host_act) begin
      ram_en = 1'b1;
      ram_a  = host_addr[AW+1:2];
      if (host_we) begin
        ram_we = 4'b0001 << host_addr[1:0];
        ram_di = {24'b0, host_wdata} << {host_addr[1:0], 3'b000};
      end
    end else if (state == ACCESS && !oob_q) begin
      ram_en = 1'b1;
      ram_a  = word_q;
      ram_we = we_q ? sel_q : '0;
      ram_di = dat_q;
    end

    if (state == RESP) begin
      if (gnt_dbus) begin
        dbus_ack = 1'b1;
        dbus_rdt = (!oob_q && !we_q) ? ram_do : '0;
      end else begin
        ibus_ack = 1'b1;
        ibus_rdt = !oob_q ? ram_do : '0;
      end
    end

    host_rdata = host_vld_q ? ram_do[{lane_q, 3'b000} +: 8] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_dbus   <= 1'b0;
      word_q     <= '0;
      oob_q      <= 1'b0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      sel_q      <= '0;
      lane_q     <= '0;
      host_vld_q <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      state      <= state_nxt;
      host_vld_q <= host_act;
      if (host_act)
        lane_q <= host_addr[1:0];
      if (grant) begin
        gnt_dbus <= pick_dbus;
        word_q   <= pick_dbus ? dbus_adr[AW+1:2] : ibus_adr[AW+1:2];
        oob_q    <= pick_dbus ? (dbus_adr[31:AW+2] != '0) : (ibus_adr[31:AW+2] != '0);
        we_q     <= pick_dbus & dbus_we;
        dat_q    <= pick_dbus ? dbus_dat : '0;
        sel_q    <= pick_dbus ? dbus_sel : '0;
      end
      if (state == ACCESS && oob_q)
        err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serv_ram_arbiter.sv
// Bench for serv_ram_arbiter: round-robin instance checked every cycle against a
// transaction-level model; a dbus-priority instance pinned by literal checks.
module tb_serv_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        host_en;
  logic [6:0]  host_addr;
  logic        host_we;
  logic [7:0]  host_wdata;
  logic        ibus_cyc;
  logic [31:0] ibus_adr;
  logic        dbus_cyc;
  logic [31:0] dbus_adr;
  logic        dbus_we;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;

  logic [7:0]  host_rdata, p1_host_rdata;
  logic        host_rdy, p1_host_rdy;
  logic [31:0] ibus_rdt, p1_ibus_rdt, dbus_rdt, p1_dbus_rdt;
  logic        ibus_ack, p1_ibus_ack, dbus_ack, p1_dbus_ack;
  logic        ram_en, p1_ram_en;
  logic [4:0]  ram_a, p1_ram_a;
  logic [3:0]  ram_we, p1_ram_we;
  logic [31:0] ram_di, p1_ram_di, ram_do, p1_ram_do;
  logic        err_oob, p1_err_oob;

  serv_ram_arbiter #(.AW(5), .DBUS_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .host_en(host_en), .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rdy(host_rdy),
    .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
    .dbus_cyc(dbus_cyc), .dbus_adr(dbus_adr), .dbus_we(dbus_we), .dbus_dat(dbus_dat),
    .dbus_sel(dbus_sel), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
    .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do),
    .err_oob(err_oob)
  );

  serv_ram_arbiter #(.AW(5), .DBUS_PRIO(1'b1)) dut_prio (
    .clk(clk), .rst_n(rst_n), .host_en(host_en), .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_rdata(p1_host_rdata), .host_rdy(p1_host_rdy),
    .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(p1_ibus_rdt), .ibus_ack(p1_ibus_ack),
    .dbus_cyc(dbus_cyc), .dbus_adr(dbus_adr), .dbus_we(dbus_we), .dbus_dat(dbus_dat),
    .dbus_sel(dbus_sel), .dbus_rdt(p1_dbus_rdt), .dbus_ack(p1_dbus_ack),
    .ram_en(p1_ram_en), .ram_a(p1_ram_a), .ram_we(p1_ram_we), .ram_di(p1_ram_di), .ram_do(p1_ram_do),
    .err_oob(p1_err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM32 macros: 1-cycle synchronous read (old data), byte write enables
  logic [31:0] init_val [32];
  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  bit          mem_rdy = 1'b0;

  always @(posedge clk) begin
    if (!mem_rdy) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= init_val[i];
        mem1[i] <= init_val[i];
      end
      ram_do    <= '0;
      p1_ram_do <= '0;
      mem_rdy   <= 1'b1;
    end else begin
      if (ram_en) begin
        ram_do <= mem0[ram_a];
        for (int i = 0; i < 4; i++)
          if (ram_we[i]) mem0[ram_a][i*8 +: 8] <= ram_di[i*8 +: 8];
      end
      if (p1_ram_en) begin
        p1_ram_do <= mem1[p1_ram_a];
        for (int i = 0; i < 4; i++)
          if (p1_ram_we[i]) mem1[p1_ram_a][i*8 +: 8] <= p1_ram_di[i*8 +: 8];
      end
    end
  end

  // Transaction model: cycle k is the interval after the k-th active edge since reset.
  // A grant at edge g puts the RAM access in cycle g and the ack in cycle g+1.
  int          k, g, hc, err_cyc;
  bit          tv, tm, t_we, t_in, last_d, err_set, sh_rdy;
  logic [31:0] t_adr, t_dat, t_rdt;
  logic [3:0]  t_sel;
  logic [7:0]  hbyte;
  logic [31:0] shadow [32];

  always @(posedge clk) begin
    if (!rst_n) begin
      if (!sh_rdy) begin
        for (int i = 0; i < 32; i++) shadow[i] = init_val[i];
        sh_rdy = 1'b1;
      end
      k = 0; tv = 1'b0; last_d = 1'b0; err_set = 1'b0; hc = -1; g = 0;
    end else begin
      if (tv && k == g) begin
        if (t_in && t_we)
          for (int i = 0; i < 4; i++)
            if (t_sel[i]) shadow[t_adr[6:2]][i*8 +: 8] = t_dat[i*8 +: 8];
        if (!t_in && !err_set) begin
          err_set = 1'b1;
          err_cyc = k + 1;
        end
      end
      if (!(tv && k < g + 2)) begin
        if (host_en) begin
          hbyte = shadow[host_addr[6:2]][{host_addr[1:0], 3'b000} +: 8];
          hc = k + 1;
          if (host_we) shadow[host_addr[6:2]][{host_addr[1:0], 3'b000} +: 8] = host_wdata;
        end else if (ibus_cyc || dbus_cyc) begin
          tm     = dbus_cyc && (!ibus_cyc || !last_d);
          last_d = tm;
          tv     = 1'b1;
          g      = k + 1;
          t_adr  = tm ? dbus_adr : ibus_adr;
          t_we   = tm && dbus_we;
          t_dat  = tm ? dbus_dat : 32'h0;
          t_sel  = tm ? dbus_sel : 4'h0;
          t_in   = (t_adr[31:7] == 25'h0);
          t_rdt  = (t_in && !t_we) ? shadow[t_adr[6:2]] : 32'h0;
        end
      end
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    logic        e_en, e_rdy, e_iack, e_dack, e_err;
    logic [4:0]  e_a;
    logic [3:0]  e_we;
    logic [31:0] e_di, e_irdt, e_drdt;
    logic [7:0]  e_hrd;
    e_en = 0; e_rdy = 0; e_iack = 0; e_dack = 0; e_err = 0;
    e_a = '0; e_we = '0; e_di = '0; e_irdt = '0; e_drdt = '0; e_hrd = '0;
    if (rst_n) begin
      if (tv && k == g) begin
        e_en = t_in;
        e_a  = t_in ? t_adr[6:2] : 5'd0;
        e_we = (t_in && t_we) ? t_sel : 4'h0;
        e_di = t_in ? t_dat : 32'h0;
      end else if (tv && k == g + 1) begin
        if (tm) begin e_dack = 1; e_drdt = t_rdt; end
        else    begin e_iack = 1; e_irdt = t_rdt; end
      end else if (host_en) begin
        e_en  = 1;
        e_rdy = 1;
        e_a   = host_addr[6:2];
        if (host_we) begin
          e_we = 4'h1 << host_addr[1:0];
          e_di = {24'h0, host_wdata} << (8 * host_addr[1:0]);
        end
      end
      if (hc == k) e_hrd = hbyte;
      e_err = err_set && (k >= err_cyc);
    end
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_a", 32'(ram_a), 32'(e_a));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_di", ram_di, e_di);
    chk("host_rdy", 32'(host_rdy), 32'(e_rdy));
    chk("host_rdata", 32'(host_rdata), 32'(e_hrd));
    chk("ibus_ack", 32'(ibus_ack), 32'(e_iack));
    chk("ibus_rdt", ibus_rdt, e_irdt);
    chk("dbus_ack", 32'(dbus_ack), 32'(e_dack));
    chk("dbus_rdt", dbus_rdt, e_drdt);
    chk("err_oob", 32'(err_oob), 32'(e_err));
    chk("prio_ack_excl", 32'(p1_ibus_ack & p1_dbus_ack), 32'h0);
  end

  logic iack_q = 1'b0, dack_q = 1'b0;
  always @(negedge clk) begin
    iack_q <= ibus_ack;
    dack_q <= dbus_ack;
  end

  function automatic logic [31:0] rand_adr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h80;
    return {25'h0, 7'($urandom_range(0, 127))};
  endfunction

  task automatic host_op(input logic [6:0] a, input logic we, input logic [7:0] d);
    @(posedge clk); #1;
    host_en = 1'b1; host_addr = a; host_we = we; host_wdata = d;
    @(negedge clk);
  endtask

  task automatic bus_quiet();
    @(posedge clk); #1;
    host_en = 1'b0; host_we = 1'b0; ibus_cyc = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
  endtask

  logic [7:0] wb [4];

  initial begin
    for (int i = 0; i < 32; i++) init_val[i] = $urandom;
    rst_n = 1'b0;
    host_en = 1'b1; host_addr = 7'h5; host_we = 1'b1; host_wdata = 8'hFF;
    ibus_cyc = 1'b1; ibus_adr = 32'h4; dbus_cyc = 1'b0; dbus_adr = '0;
    dbus_we = 1'b0; dbus_dat = '0; dbus_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_host_rdy", 32'(host_rdy), 32'h0);
    chk("rst_ibus_ack", 32'(ibus_ack), 32'h0);
    #1 rst_n = 1'b1;
    host_en = 1'b0; host_we = 1'b0; ibus_cyc = 1'b0;

    // host byte program and readback
    wb[0] = 8'h13; wb[1] = 8'h00; wb[2] = 8'h00; wb[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      host_op(7'(i), 1'b1, wb[i]);
      chk("host_wr_we", 32'(ram_we), 32'h1 << i);
      chk("host_wr_rdy", 32'(host_rdy), 32'h1);
    end
    host_op(7'd2, 1'b0, 8'h00);
    host_op(7'd0, 1'b0, 8'h00);
    chk("host_rd_byte2", 32'(host_rdata), 32'h00);
    bus_quiet();
    @(negedge clk);
    chk("host_rd_byte0", 32'(host_rdata), 32'h13);

    // ibus fetch of word 1
    wb[0] = 8'hEF; wb[1] = 8'hBE; wb[2] = 8'hAD; wb[3] = 8'hDE;
    for (int i = 0; i < 4; i++) host_op(7'(4 + i), 1'b1, wb[i]);
    @(posedge clk); #1 host_en = 1'b0; host_we = 1'b0; ibus_cyc = 1'b1; ibus_adr = 32'h4;
    @(negedge clk);
    @(negedge clk);
    chk("fetch_ram_en", 32'(ram_en), 32'h1);
    chk("fetch_ram_a", 32'(ram_a), 32'h1);
    @(negedge clk);
    chk("fetch_ack", 32'(ibus_ack), 32'h1);
    chk("fetch_rdt", ibus_rdt, 32'hDEADBEEF);
    chk("fetch_no_dack", 32'(dbus_ack), 32'h0);
    bus_quiet();

    // partial dbus write then fetch of the same word
    for (int i = 0; i < 4; i++) host_op(7'(8 + i), 1'b1, 8'h00);
    @(posedge clk); #1 host_en = 1'b0; host_we = 1'b0;
    dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h8; dbus_dat = 32'hAABBCCDD; dbus_sel = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    chk("dwr_ram_we", 32'(ram_we), 32'h6);
    chk("dwr_ram_di", ram_di, 32'hAABBCCDD);
    @(negedge clk);
    chk("dwr_ack", 32'(dbus_ack), 32'h1);
    chk("dwr_rdt", dbus_rdt, 32'h0);
    @(posedge clk); #1 dbus_cyc = 1'b0; dbus_we = 1'b0; ibus_cyc = 1'b1; ibus_adr = 32'h8;
    repeat (3) @(negedge clk);
    chk("merge_rdt", ibus_rdt, 32'h00BBCC00);
    bus_quiet();
    @(negedge clk);

    // both masters hold requests: last grant was ibus, so round-robin starts with dbus
    @(posedge clk); #1 ibus_cyc = 1'b1; ibus_adr = 32'h4; dbus_cyc = 1'b1; dbus_adr = 32'hC;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rr_iack", 32'(ibus_ack), 32'((c % 3 == 2) && ((c / 3) % 2 == 1)));
      chk("rr_dack", 32'(dbus_ack), 32'((c % 3 == 2) && ((c / 3) % 2 == 0)));
      chk("prio_dack", 32'(p1_dbus_ack), 32'(c % 3 == 2));
      chk("prio_iack", 32'(p1_ibus_ack), 32'h0);
    end
    bus_quiet();
    @(negedge clk);

    // out-of-range dbus read
    @(posedge clk); #1 dbus_cyc = 1'b1; dbus_adr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    chk("oob_ram_en", 32'(ram_en), 32'h0);
    chk("oob_err_pre", 32'(err_oob), 32'h0);
    @(negedge clk);
    chk("oob_ack", 32'(dbus_ack), 32'h1);
    chk("oob_rdt", dbus_rdt, 32'h0);
    chk("oob_err", 32'(err_oob), 32'h1);
    bus_quiet();
    repeat (3) @(negedge clk);
    chk("oob_err_sticky", 32'(err_oob), 32'h1);

    // reset during the ACCESS cycle of a dbus write
    @(posedge clk); #1 dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h10; dbus_sel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we_pre", 32'(ram_we), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(ram_we), 32'h0);
    chk("rst_mid_en", 32'(ram_en), 32'h0);
    chk("rst_mid_err", 32'(err_oob), 32'h0);
    dbus_cyc = 1'b0; dbus_we = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_after_dack", 32'(dbus_ack), 32'h0);
    chk("rst_after_err", 32'(err_oob), 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!ibus_cyc || iack_q) begin
        ibus_cyc = ($urandom_range(0, 1) == 1);
        ibus_adr = rand_adr();
      end
      if (!dbus_cyc || dack_q) begin
        dbus_cyc = ($urandom_range(0, 1) == 1);
        dbus_adr = rand_adr();
        dbus_we  = $urandom_range(0, 1) == 1;
        dbus_dat = $urandom;
        dbus_sel = 4'($urandom);
      end
      host_en    = ($urandom_range(0, 3) == 0);
      host_addr  = 7'($urandom);
      host_we    = $urandom_range(0, 1) == 1;
      host_wdata = 8'($urandom);
    end
    bus_quiet();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
